fifo_rr_sched: RTL

Round-robin read scheduler sharing one AXI-Stream master among NUM_CH first-word-fall-through FIFOs. Grants one FIFO at a time, locks the grant for a whole packet (until a word with its last bit set), and drives a registered output stage tagged with the source channel. Sits between the per-channel fifo_fwft instances and the downstream stream consumer.

---
 rtl/axis_rr_arb.sv | 54 +++++
 rtl/fifo_rr_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arb.sv
// ---------------------------------------------------------------------------
// axis_rr_arb
// Purely combinational round-robin selector. Starting one position after
// i_last_grant and wrapping, it returns the first channel whose request bit
// is set. Channel indices >= NUM_CH cannot be returned.
//
// Ports
//   i_req         NUM_CH    per-channel request
//   i_last_grant  ID_WIDTH  most recently completed grant (search starts after it)
//   o_valid       1         at least one request present
//   o_grant       ID_WIDTH  selected channel index (0 when o_valid is low)
// ---------------------------------------------------------------------------
module axis_rr_arb #(
    parameter int NUM_CH   = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_CH-1:0]   i_req,
    input  logic [ID_WIDTH-1:0] i_last_grant,
    output logic                o_valid,
    output logic [ID_WIDTH-1:0] o_grant
);
    localparam int NUM_IDX = 2 ** ID_WIDTH;

    // Request vector padded to the full index range so it can be indexed
    // with an ID_WIDTH-bit value; padding entries never request.
    logic [NUM_IDX-1:0] w_req_pad;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_IDX; gi++) begin : g_pad
            if (gi < NUM_CH) begin : g_real
                assign w_req_pad[gi] = i_req[gi];
            end else begin : g_none
                assign w_req_pad[gi] = 1'b0;
            end
        end
    endgenerate

    // Walk offsets from farthest to nearest so the nearest requester after
    // i_last_grant overwrites any farther one.
    always_comb begin
        int c;
        c       = 0;
        o_valid = 1'b0;
        o_grant = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            c = (int'(i_last_grant) + k) % NUM_CH;
            if (w_req_pad[c[ID_WIDTH-1:0]]) begin
                o_valid = 1'b1;
                o_grant = c[ID_WIDTH-1:0];
            end
        end
    end
endmodule

// File: rtl/fifo_rr_sched.sv
// ---------------------------------------------------------------------------
// fifo_rr_sched
// Shares one AXI-Stream master among NUM_CH first-word-fall-through FIFOs.
// In ST_IDLE a round-robin pick is made among enabled, non-empty channels;
// in ST_LOCK the granted FIFO is drained into a single registered output
// slice until a word with last=1 is popped. Output words carry the source
// channel in tdest.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   fifo_dout       flattened FWFT heads, {last, data} per channel
//   fifo_empty      per-channel empty
//   fifo_rd_en      per-channel pop (one-hot or zero)
//   ch_en           per-channel arbitration enable
//   m_axis_*        registered output stream (tdest = source channel)
//   busy            high while a packet is locked
//   grant_id        current / last granted channel
// ---------------------------------------------------------------------------
module fifo_rr_sched #(
    parameter int NUM_CH     = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ID_WIDTH   = 2
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_CH*(DATA_WIDTH+1)-1:0]    fifo_dout,
    input  logic [NUM_CH-1:0]                   fifo_empty,
    output logic [NUM_CH-1:0]                   fifo_rd_en,
    input  logic [NUM_CH-1:0]                   ch_en,
    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic                                m_axis_tlast,
    output logic [ID_WIDTH-1:0]                 m_axis_tdest,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                busy,
    output logic [ID_WIDTH-1:0]                 grant_id
);
    localparam int                  SLICE_W = DATA_WIDTH + 1;
    localparam int                  NUM_IDX = 2 ** ID_WIDTH;
    localparam logic [ID_WIDTH-1:0] LAST_CH = ID_WIDTH'(NUM_CH - 1);
    localparam logic                ST_IDLE = 1'b0;
    localparam logic                ST_LOCK = 1'b1;

    logic                  r_state;
    logic                  w_state_next;
    logic [ID_WIDTH-1:0]   r_grant;
    logic [ID_WIDTH-1:0]   r_last_grant;
    logic                  r_tvalid;
    logic                  r_tlast;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic [ID_WIDTH-1:0]   r_tdest;

    logic [NUM_CH-1:0]     w_req;
    logic                  w_arb_valid;
    logic [ID_WIDTH-1:0]   w_arb_grant;
    logic [SLICE_W-1:0]    w_head_arr [NUM_IDX];
    logic [NUM_IDX-1:0]    w_empty_pad;
    logic [SLICE_W-1:0]    w_head;
    logic                  w_head_last;
    logic                  w_grant_empty;
    logic                  w_slice_rdy;
    logic                  w_pop;
    logic                  w_pop_last;
    logic [NUM_IDX-1:0]    w_rd_pad;

    // Unflatten the FIFO heads; unused index slots look permanently empty.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IDX; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_real
                assign w_head_arr[gi]  = fifo_dout[gi*SLICE_W +: SLICE_W];
                assign w_empty_pad[gi] = fifo_empty[gi];
            end else begin : g_pad
                assign w_head_arr[gi]  = '0;
                assign w_empty_pad[gi] = 1'b1;
            end
        end
    endgenerate

    assign w_req = ~fifo_empty & ch_en;

    axis_rr_arb #(
        .NUM_CH   (NUM_CH),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_arb_valid),
        .o_grant      (w_arb_grant)
    );

    assign w_head        = w_head_arr[r_grant];
    assign w_head_last   = w_head[DATA_WIDTH];
    assign w_grant_empty = w_empty_pad[r_grant];

    // Single-entry slice: a new word may enter when the slot is free or is
    // being emptied this cycle, hence the combinational path from tready.
    // The lock ignores ch_en so a packet always completes once started.
    assign w_slice_rdy = !r_tvalid || m_axis_tready;
    assign w_pop       = (r_state == ST_LOCK) && !w_grant_empty && w_slice_rdy && !rst;
    assign w_pop_last  = w_pop && w_head_last;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_arb_valid) w_state_next = ST_LOCK;
            ST_LOCK: if (w_pop_last)  w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy     = (r_state == ST_LOCK);
        w_rd_pad = '0;
        if (w_pop) begin
            w_rd_pad[r_grant] = 1'b1;
        end
        fifo_rd_en = w_rd_pad[NUM_CH-1:0];
    end

    // Grant bookkeeping: r_grant latches at arbitration, r_last_grant only
    // advances once the packet's last word has left the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_grant      <= LAST_CH;
            r_last_grant <= LAST_CH;
        end else begin
            if (r_state == ST_IDLE && w_arb_valid) begin
                r_grant <= w_arb_grant;
            end
            if (w_pop_last) begin
                r_last_grant <= r_grant;
            end
        end
    end

    // Output register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tvalid <= 1'b0;
            r_tdata  <= '0;
            r_tlast  <= 1'b0;
            r_tdest  <= '0;
        end else if (w_pop) begin
            r_tvalid <= 1'b1;
            r_tdata  <= w_head[DATA_WIDTH-1:0];
            r_tlast  <= w_head_last;
            r_tdest  <= r_grant;
        end else if (m_axis_tready) begin
            r_tvalid <= 1'b0;
        end
    end

    assign m_axis_tvalid = r_tvalid;
    assign m_axis_tdata  = r_tdata;
    assign m_axis_tlast  = r_tlast;
    assign m_axis_tdest  = r_tdest;
    assign grant_id      = r_grant;
endmodule
